// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the wishbone master arbiter.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Grant index width; a single channel still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width; a disabled watchdog keeps a 1-bit counter.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_master_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting index after `last`, wrapping.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          vld
);

  int best_d;

  // Distance 0 is the channel right after `last`; smallest distance wins.
  always_comb begin
    best_d = N;
    gnt    = '0;
    for (int c = 0; c < N; c++) begin
      if (req[c] && (((c - int'(last) + N - 1) % N) < best_d)) begin
        best_d = (c - int'(last) + N - 1) % N;
        gnt    = IW'(c);
      end
    end
    vld = |req;
  end

endmodule

// File: rtl/wb_master_arb.sv
// N-channel wishbone master front-end: round-robin grant, one bus cycle at a
// time, registered ack/err pulses back to the owning channel, timeout watchdog.
module wb_master_arb
  import wb_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 30,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH-1:0]           i_we,
  input  logic [N_CH*SEL_WIDTH-1:0] i_sel,
  input  logic [N_CH*ADR_WIDTH-1:0] i_adr,
  input  logic [N_CH*DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0]     o_dout,
  output logic [N_CH-1:0]           o_ack,
  output logic [N_CH-1:0]           o_err,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [SEL_WIDTH-1:0]      o_wb_sel,
  output logic [ADR_WIDTH+1:0]      o_wb_adr,
  output logic [DATA_WIDTH-1:0]     o_wb_dat,
  input  logic [DATA_WIDTH-1:0]     i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err
);

  localparam int IW = idx_w(N_CH);
  localparam int TW = cnt_w(TIMEOUT);

  state_t          state, state_nxt;
  logic [IW-1:0]   last, gnt, arb_gnt;
  logic            arb_vld;
  logic [TW-1:0]   cnt;
  logic [N_CH-1:0] elig, ack_vec, err_vec;
  logic            do_grant, do_ack, do_err, tmo_hit;

  logic                  m_we;
  logic [SEL_WIDTH-1:0]  m_sel;
  logic [ADR_WIDTH-1:0]  m_adr;
  logic [DATA_WIDTH-1:0] m_din;

  // Masking the channel still holding its pulse stops a re-issue while it drops req.
  assign elig    = i_req & ~(o_ack | o_err);
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));

  rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
    .req  (elig),
    .last (last),
    .gnt  (arb_gnt),
    .vld  (arb_vld)
  );

  always_comb begin
    m_we  = 1'b0;
    m_sel = '0;
    m_adr = '0;
    m_din = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (arb_gnt == IW'(c)) begin
        m_we  = i_we[c];
        m_sel = i_sel[c*SEL_WIDTH +: SEL_WIDTH];
        m_adr = i_adr[c*ADR_WIDTH +: ADR_WIDTH];
        m_din = i_din[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = BUS;
      BUS:     if (do_ack || do_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Error beats ack; the watchdog only fires when the slave stays silent.
  always_comb begin
    do_grant = 1'b0;
    do_ack   = 1'b0;
    do_err   = 1'b0;
    case (state)
      IDLE: do_grant = arb_vld;
      BUS: begin
        do_err = i_wb_err | (tmo_hit & ~i_wb_ack);
        do_ack = i_wb_ack & ~i_wb_err;
      end
      default: ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      ack_vec[c] = do_ack && (gnt == IW'(c));
      err_vec[c] = do_err && (gnt == IW'(c));
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      last     <= IW'(N_CH - 1);
      gnt      <= '0;
      cnt      <= '0;
      o_dout   <= '0;
      o_ack    <= '0;
      o_err    <= '0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we  <= 1'b0;
      o_wb_sel <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
    end else begin
      o_ack <= ack_vec;
      o_err <= err_vec;
      if (do_grant) begin
        gnt      <= arb_gnt;
        last     <= arb_gnt;
        cnt      <= '0;
        o_wb_cyc <= 1'b1;
        o_wb_stb <= 1'b1;
        o_wb_we  <= m_we;
        o_wb_sel <= m_sel;
        o_wb_adr <= {m_adr, 2'b00};
        o_wb_dat <= m_din;
      end else if (state == BUS) begin
        cnt <= cnt + TW'(1);
        if (do_err || do_ack) begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          o_dout   <= do_err ? '0 : i_wb_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb (2 channels, 4-cycle watchdog).
module tb_wb_master_arb;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic [1:0]  i_req, i_we;
  logic [7:0]  i_sel;
  logic [59:0] i_adr;
  logic [63:0] i_din;
  logic [31:0] o_dout, o_wb_dat, i_wb_dat;
  logic [1:0]  o_ack, o_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr;
  logic        i_wb_ack, i_wb_err;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  wb_master_arb #(.N_CH(2), .DATA_WIDTH(32), .ADR_WIDTH(30), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_req(i_req), .i_we(i_we), .i_sel(i_sel),
    .i_adr(i_adr), .i_din(i_din), .o_dout(o_dout), .o_ack(o_ack), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int n;
    int cyc_cnt;
    i_arst = 1'b1; i_req = '0; i_we = '0; i_sel = '0; i_adr = '0; i_din = '0;
    i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    tick(); tick();
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dout", o_dout, 0);
    i_arst = 1'b0;
    tick();

    // single read on ch0
    i_adr[29:0] = 30'h100; i_req = 2'b01;
    tick();
    chk("rd_cyc", {o_wb_cyc, o_wb_stb}, 2'b11);
    chk("rd_adr", o_wb_adr, 32'h400);
    chk("rd_we", o_wb_we, 0);
    tick(); tick();
    i_wb_ack = 1'b1; i_wb_dat = 32'hDEADBEEF;
    tick();
    i_wb_ack = 1'b0;
    chk("rd_ack", o_ack, 2'b01);
    chk("rd_dout", o_dout, 32'hDEADBEEF);
    chk("rd_cyc_lo", o_wb_cyc, 0);
    tick();
    chk("rd_pulse", o_ack, 2'b00);
    chk("rd_noreissue", o_wb_cyc, 0);
    i_req = 2'b00;
    tick();

    // write on ch1, fields must stay latched after grant
    i_we = 2'b10; i_sel[7:4] = 4'b0011; i_din[63:32] = 32'h12345678;
    i_adr[59:30] = 30'h55; i_req = 2'b10;
    tick();
    chk("wr_cyc", o_wb_cyc, 1);
    chk("wr_we", o_wb_we, 1);
    chk("wr_sel", o_wb_sel, 4'b0011);
    chk("wr_dat", o_wb_dat, 32'h12345678);
    chk("wr_adr", o_wb_adr, 32'h154);
    i_din[63:32] = 32'hFFFFFFFF; i_sel[7:4] = 4'hF; i_we = 2'b00;
    tick();
    chk("wr_dat_hold", o_wb_dat, 32'h12345678);
    chk("wr_sel_hold", o_wb_sel, 4'b0011);
    chk("wr_we_hold", o_wb_we, 1);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    chk("wr_ack", o_ack, 2'b10);
    chk("wr_noerr", o_err, 2'b00);
    i_req = 2'b00;
    tick();

    // fairness: both channels request continuously, slave acks next cycle
    n = 0;
    i_req = 2'b11; i_wb_dat = 32'hCAFE0000;
    for (int it = 0; it < 40 && n < 8; it++) begin
      i_wb_ack = o_wb_cyc;
      tick();
      if (o_ack != 2'b00) begin
        chk("fair_gnt", o_ack, (n % 2 == 0) ? 2'b01 : 2'b10);
        n++;
      end
    end
    chk("fair_cnt", n, 8);
    i_req = 2'b00; i_wb_ack = 1'b0;
    tick(); tick();

    // watchdog: slave never answers
    cyc_cnt = 0;
    i_req = 2'b01;
    for (int it = 0; it < 20; it++) begin
      tick();
      if (o_wb_cyc) cyc_cnt++;
      if (o_err != 2'b00) break;
    end
    i_req = 2'b00;
    chk("tmo_len", cyc_cnt, 4);
    chk("tmo_err", o_err, 2'b01);
    chk("tmo_dout", o_dout, 0);
    chk("tmo_noack", o_ack, 0);
    tick();
    i_adr[29:0] = 30'h10; i_req = 2'b01;
    tick();
    chk("post_tmo_cyc", o_wb_cyc, 1);
    chk("post_tmo_adr", o_wb_adr, 32'h40);
    i_wb_ack = 1'b1; i_wb_dat = 32'h11;
    tick();
    i_wb_ack = 1'b0; i_req = 2'b00;
    chk("post_tmo_ack", o_ack, 2'b01);
    chk("post_tmo_dout", o_dout, 32'h11);
    tick();

    // ack and err together: error wins
    i_req = 2'b10;
    tick();
    i_wb_ack = 1'b1; i_wb_err = 1'b1;
    tick();
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_req = 2'b00;
    chk("both_err", o_err, 2'b10);
    chk("both_noack", o_ack, 2'b00);
    tick();

    // async reset mid-cycle, then ch0 wins first
    i_adr[29:0] = 30'h20; i_adr[59:30] = 30'h30; i_req = 2'b10;
    tick();
    chk("mid_cyc", o_wb_cyc, 1);
    i_req = 2'b11;
    i_arst = 1'b1;
    #1;
    chk("mid_rst_cyc", {o_wb_cyc, o_wb_stb}, 2'b00);
    chk("mid_rst_ack", {o_ack, o_err}, 4'b0000);
    tick();
    i_arst = 1'b0;
    tick();
    chk("rst_gnt_cyc", o_wb_cyc, 1);
    chk("rst_gnt_ch0", o_wb_adr, 32'h80);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0; i_req = 2'b00;
    chk("rst_gnt_ack", o_ack, 2'b01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
